// File: rtl/scene_loader.sv
// Byte-stream scene loader: parses A5/N framed objects and writes each assembled
// object into an external scene memory, committing the object count on completion.
module scene_loader #(
  parameter int unsigned OBJ_WIDTH = 673,
  parameter int unsigned DEPTH     = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [$clog2(DEPTH)-1:0]     wr_addr,
  output logic [OBJ_WIDTH-1:0]         wr_data,
  output logic                         wr_en,
  output logic [$clog2(DEPTH+1)-1:0]   num_objs,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned NB = (OBJ_WIDTH + 7) / 8;
  localparam int unsigned AB = NB * 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [7:0]  START_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, DONE} state_t;

  state_t            r_state, w_state;
  logic [CW-1:0]     r_n, w_n;
  logic [AW-1:0]     r_idx, w_idx;
  logic [BW-1:0]     r_bcnt, w_bcnt;
  logic [AB-1:0]     r_asm, w_asm;
  logic [AW-1:0]     r_wr_addr, w_wr_addr;
  logic [OBJ_WIDTH-1:0] r_wr_data, w_wr_data;
  logic [CW-1:0]     r_num, w_num;
  logic              r_err, w_err;

  logic              w_xfer;
  logic              w_bad_count;
  logic [AB+7:0]     w_cat;

  assign w_xfer      = in_valid && in_ready;
  assign w_bad_count = (in_data == 8'd0) || (32'(in_data) > DEPTH);
  // New byte enters at the top; after NB shifts byte 0 sits in the low lane.
  assign w_cat       = {in_data, r_asm};

  // Next-state and datapath update
  always_comb begin
    w_state   = r_state;
    w_n       = r_n;
    w_idx     = r_idx;
    w_bcnt    = r_bcnt;
    w_asm     = r_asm;
    w_wr_addr = r_wr_addr;
    w_wr_data = r_wr_data;
    w_num     = r_num;
    w_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer && (in_data == START_BYTE)) w_state = COUNT;
      end
      COUNT: begin
        if (w_xfer) begin
          if (w_bad_count) begin
            w_err   = 1'b1;
            w_state = IDLE;
          end else begin
            w_n     = CW'(in_data);
            w_idx   = '0;
            w_bcnt  = '0;
            w_state = DATA;
          end
        end
      end
      DATA: begin
        if (w_xfer) begin
          w_asm = w_cat[AB+7:8];
          if (r_bcnt == BW'(NB - 1)) begin
            w_wr_addr = r_idx;
            w_wr_data = w_cat[OBJ_WIDTH+7:8];
            w_state   = WRITE;
          end else begin
            w_bcnt = r_bcnt + BW'(1);
          end
        end
      end
      WRITE: begin
        if (CW'(r_idx) == (r_n - CW'(1))) begin
          w_num   = r_n;
          w_state = DONE;
        end else begin
          w_idx   = r_idx + AW'(1);
          w_bcnt  = '0;
          w_state = DATA;
        end
      end
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_n       <= '0;
      r_idx     <= '0;
      r_bcnt    <= '0;
      r_asm     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_num     <= CW'(1);
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_n       <= w_n;
      r_idx     <= w_idx;
      r_bcnt    <= w_bcnt;
      r_asm     <= w_asm;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
      r_num     <= w_num;
      r_err     <= w_err;
    end
  end

  // Strobes decode directly from the state register, so they are glitch-free.
  assign in_ready = (r_state == IDLE) || (r_state == COUNT) || (r_state == DATA);
  assign busy     = (r_state != IDLE);
  assign wr_en    = (r_state == WRITE);
  assign done     = (r_state == DONE);
  assign err      = r_err;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign num_objs = r_num;

endmodule

// File: tb/tb_scene_loader.sv
// Self-checking bench for scene_loader (OBJ_WIDTH=12, DEPTH=4): a frame-parser
// model predicts writes/strobes per cycle, plus literal checks per scenario.
module tb_scene_loader;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wr_en;
  logic [2:0]  num_objs;
  logic        busy;
  logic        done;
  logic        err;

  scene_loader #(.OBJ_WIDTH(12), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .num_objs(num_objs), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Frame-parser model: phase 0 hunts for A5, 1 awaits count, 2 collects payload.
  int          m_phase = 0;
  int          m_n = 0, m_obj = 0, m_bytes = 0;
  logic [15:0] m_acc = '0;
  int          m_wr_cyc = -1, m_done_cyc = -1, m_err_cyc = -1, m_num_cyc = -1;
  logic [1:0]  m_wr_addr = '0;
  logic [11:0] m_wr_data = '0;
  logic [2:0]  m_num_val = 3'd1;
  logic [2:0]  exp_num = 3'd1;
  logic [1:0]  exp_addr = '0;
  logic [11:0] exp_data = '0;

  int          log_n = 0, done_cnt = 0, err_cnt = 0;
  logic [1:0]  log_addr [0:63];
  logic [11:0] log_data [0:63];

  task automatic model_byte(input logic [7:0] b);
    case (m_phase)
      0: if (b == 8'hA5) m_phase = 1;
      1: begin
        if (b == 8'd0 || b > 8'd4) begin
          m_err_cyc = cyc + 1;
          m_phase = 0;
        end else begin
          m_n = int'(b); m_obj = 0; m_bytes = 0; m_acc = '0;
          m_phase = 2;
        end
      end
      default: begin
        m_acc = m_acc | (16'(b) << (8 * m_bytes));
        m_bytes++;
        if (m_bytes == 2) begin
          m_wr_cyc = cyc + 1;
          m_wr_addr = 2'(m_obj);
          m_wr_data = m_acc[11:0];
          m_obj++; m_bytes = 0; m_acc = '0;
          if (m_obj == m_n) begin
            m_done_cyc = cyc + 2;
            m_num_cyc = cyc + 2;
            m_num_val = 3'(m_n);
            m_phase = 0;
          end
        end
      end
    endcase
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic wr_due, done_due, err_due;
    if (rst) begin
      m_phase = 0; m_bytes = 0; m_acc = '0;
      m_wr_cyc = -1; m_done_cyc = -1; m_err_cyc = -1; m_num_cyc = -1;
      exp_num = 3'd1; exp_addr = '0; exp_data = '0;
    end else begin
      wr_due   = (cyc == m_wr_cyc);
      done_due = (cyc == m_done_cyc);
      err_due  = (cyc == m_err_cyc);
      if (cyc == m_num_cyc) exp_num = m_num_val;
      if (wr_due) begin
        exp_addr = m_wr_addr;
        exp_data = m_wr_data;
      end
      check("wr_en", 32'(wr_en), 32'(wr_due));
      check("done", 32'(done), 32'(done_due));
      check("err", 32'(err), 32'(err_due));
      check("in_ready", 32'(in_ready), 32'(!(wr_due || done_due)));
      check("busy", 32'(busy), 32'((m_phase != 0) || wr_due || done_due));
      check("num_objs", 32'(num_objs), 32'(exp_num));
      check("wr_addr", 32'(wr_addr), 32'(exp_addr));
      check("wr_data", 32'(wr_data), 32'(exp_data));
      if (wr_en && log_n < 64) begin
        log_addr[log_n] = wr_addr;
        log_data[log_n] = wr_data;
        log_n++;
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (in_valid && in_ready) model_byte(in_data);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", 32'(0), 32'(1));
    if (gap > 0) begin
      in_valid = 1'b0;
      idle(gap);
    end
  endtask

  task automatic send_q(input bq_t q, input int gap);
    foreach (q[i]) send(q[i], gap);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t q;
    int  base, dbase, ebase;

    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_num_objs", 32'(num_objs), 32'(1));
    check("rst_wr_addr", 32'(wr_addr), 32'(0));
    check("rst_wr_data", 32'(wr_data), 32'(0));
    check("rst_strobes", 32'({wr_en, done, err}), 32'(0));
    @(posedge clk); #1;

    // Two-object frame with gaps between bytes
    base = log_n; dbase = done_cnt;
    q = '{8'hA5, 8'h02, 8'h34, 8'hF2, 8'h78, 8'hA6};
    send_q(q, 1);
    idle(4);
    check("s1_nwrites", 32'(log_n - base), 32'(2));
    check("s1_addr0", 32'(log_addr[base]), 32'(0));
    check("s1_data0", 32'(log_data[base]), 32'h234);
    check("s1_addr1", 32'(log_addr[base+1]), 32'(1));
    check("s1_data1", 32'(log_data[base+1]), 32'h678);
    check("s1_done", 32'(done_cnt - dbase), 32'(1));
    check("s1_num", 32'(num_objs), 32'(2));

    // Rejected counts, then a valid frame
    base = log_n; ebase = err_cnt;
    q = '{8'hA5, 8'h05};
    send_q(q, 2);
    idle(3);
    q = '{8'hA5, 8'h00};
    send_q(q, 0);
    idle(3);
    check("s3_errs", 32'(err_cnt - ebase), 32'(2));
    check("s3_nowrite", 32'(log_n - base), 32'(0));
    check("s3_num_kept", 32'(num_objs), 32'(2));
    q = '{8'hA5, 8'h01, 8'h12, 8'h03};
    send_q(q, 2);
    idle(4);
    check("s3_nwrites", 32'(log_n - base), 32'(1));
    check("s3_data0", 32'(log_data[base]), 32'h312);
    check("s3_num", 32'(num_objs), 32'(1));

    // Junk before start byte, A5 inside payload
    base = log_n;
    q = '{8'h11, 8'h22, 8'hA5, 8'h01, 8'hCD, 8'hAB};
    send_q(q, 1);
    idle(4);
    check("s2_nwrites", 32'(log_n - base), 32'(1));
    check("s2_addr0", 32'(log_addr[base]), 32'(0));
    check("s2_data0", 32'(log_data[base]), 32'hBCD);
    check("s2_num", 32'(num_objs), 32'(1));
    base = log_n;
    q = '{8'hA5, 8'h01, 8'hA5, 8'h0A};
    send_q(q, 0);
    idle(4);
    check("s2b_data0", 32'(log_data[base]), 32'hAA5);

    // Valid held continuously across WRITE cycles
    base = log_n;
    q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q(q, 0);
    idle(4);
    check("s4_nwrites", 32'(log_n - base), 32'(2));
    check("s4_data0", 32'(log_data[base]), 32'h211);
    check("s4_data1", 32'(log_data[base+1]), 32'h433);
    check("s4_addr1", 32'(log_addr[base+1]), 32'(1));
    check("s4_num", 32'(num_objs), 32'(2));

    // Reset mid-frame, then a full frame
    base = log_n;
    q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03};
    send_q(q, 0);
    idle(1);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5;
    idle(1);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(1);
    check("s5_nwrites", 32'(log_n - base), 32'(1));
    check("s5_data0", 32'(log_data[base]), 32'h201);
    check("s5_num", 32'(num_objs), 32'(1));
    check("s5_busy", 32'(busy), 32'(0));
    base = log_n;
    q = '{8'hA5, 8'h01, 8'h55, 8'h66};
    send_q(q, 0);
    idle(4);
    check("s5b_nwrites", 32'(log_n - base), 32'(1));
    check("s5b_data0", 32'(log_data[base]), 32'h655);
    check("s5b_num", 32'(num_objs), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scene_loader.md
SCENE_LOADER -- requirements
Module: scene_loader

Interface
REQ-001 SHALL have parameter OBJ_WIDTH, default 673, meaning the width in bits of one packed scene object word.
REQ-002 SHALL have parameter DEPTH, default 128, meaning the scene memory depth in objects; the legal range is 2..255.
REQ-003 SHALL have port clk, input, width 1: the clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, width 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_data, input, width 8: the byte-stream payload.
REQ-006 SHALL have port in_valid, input, width 1: the source presents a byte.
REQ-007 SHALL have port in_ready, output, width 1: the loader accepts a byte; a transfer occurs when in_valid and in_ready are both 1.
REQ-008 SHALL have port wr_addr, output, width $clog2(DEPTH): the scene memory write address.
REQ-009 SHALL have port wr_data, output, width OBJ_WIDTH: the scene memory write data.
REQ-010 SHALL have port wr_en, output, width 1: a one-cycle write strobe.
REQ-011 SHALL have port num_objs, output, width $clog2(DEPTH+1): the object count of the last committed scene.
REQ-012 SHALL have port busy, output, width 1: high whenever the state is not IDLE.
REQ-013 SHALL have port done, output, width 1: a one-cycle pulse on successful load.
REQ-014 SHALL have port err, output, width 1: a one-cycle pulse on a rejected frame header.

Function
REQ-015 SHALL accept frames of the form: 0xA5 start byte, count byte N, then N objects of NB = ceil(OBJ_WIDTH/8) bytes each, least-significant byte first.
REQ-016 SHALL place byte k of an object at bits [8k+7:8k]; bits at or above OBJ_WIDTH in the last byte SHALL be discarded.
REQ-017 SHALL implement states IDLE, COUNT, DATA, WRITE and DONE.
REQ-018 In IDLE, in_ready SHALL be 1; an accepted 0xA5 SHALL go to COUNT; any other accepted byte SHALL be dropped with no state change.
REQ-019 In COUNT, in_ready SHALL be 1; an accepted N in 1..DEPTH SHALL latch N, clear the object index and byte counter, and go to DATA.
REQ-020 In COUNT, an accepted N of 0 or greater than DEPTH SHALL pulse err for one cycle, go to IDLE, and leave num_objs unchanged.
REQ-021 In DATA, in_ready SHALL be 1; each accepted byte SHALL be shifted into the assembly register and the byte counter incremented; acceptance of byte NB-1 SHALL go to WRITE.
REQ-022 In WRITE, in_ready SHALL be 0, wr_en SHALL be 1 for exactly that cycle, wr_addr SHALL equal the object index, and wr_data SHALL equal the assembled object.
REQ-023 From WRITE, if the object index equals N-1 the state SHALL go to DONE; otherwise the index SHALL increment, the byte counter SHALL clear, and the state SHALL go to DATA.
REQ-024 In DONE, in_ready SHALL be 0, done SHALL be 1 for one cycle, num_objs SHALL load N on the same edge on which done rises, and the next state SHALL be IDLE.
REQ-025 A byte of 0xA5 arriving in DATA SHALL be treated as payload, not as a resynchronising start.
REQ-026 Gaps in in_valid SHALL stall the state machine in place with no timeout.
REQ-027 Memory entries written before an aborted or reset frame SHALL remain written; num_objs SHALL change only in DONE.
REQ-028 wr_addr and wr_data SHALL hold their last values when wr_en is 0.
REQ-029 Byte-to-write latency SHALL be one cycle: wr_en asserts in the cycle after the final object byte is accepted.

Reset
REQ-030 On rst, the state SHALL go to IDLE, index and byte counter SHALL clear, wr_en/done/err/busy SHALL be 0, in_ready SHALL be 1, num_objs SHALL be 1, and wr_addr/wr_data SHALL be 0.
REQ-031 Assertion of rst mid-frame SHALL abort the frame; bytes presented while rst is high SHALL be ignored.

Verification (OBJ_WIDTH=12, DEPTH=4, NB=2)
REQ-032 Stream A5 02 34 F2 78 A6 -> writes (addr 0, data 0x234) and (addr 1, data 0x678), each as a one-cycle wr_en; done pulses; num_objs=2.
REQ-033 Stream 11 22 A5 01 CD AB -> junk dropped; single write (addr 0, data 0xBCD); num_objs=1.
REQ-034 Stream A5 05, and separately A5 00 -> err pulses after the count byte; no wr_en; num_objs is unchanged; A5 01 12 03 afterwards loads correctly (addr 0, data 0x312).
REQ-035 in_valid held high continuously with A5 02 and 4 payload bytes -> in_ready is 0 in the WRITE cycles; no byte is lost or duplicated; the byte held during WRITE is accepted in the following cycle.
REQ-036 rst pulsed after A5 03 and 3 payload bytes -> addr 0 is written once; after reset num_objs=1 and busy=0; a subsequent full frame loads normally.
